// File: rtl/hyperbus_responder.sv
// HyperBus responder: CA capture, fixed 2x latency, linear burst
// to a single-port word memory, plus a read-only ID register space.
module hyperbus_responder #(
    parameter int          ADDR_WIDTH = 16,
    parameter int          LATENCY    = 6,
    parameter logic [15:0] ID_REG     = 16'h0C81
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cs_ni,
    input  logic [15:0]           dq_i,
    input  logic [1:0]            rwds_i,
    output logic [15:0]           dq_o,
    output logic                  dq_oe_o,
    output logic                  rwds_o,
    output logic                  rwds_oe_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [15:0]           mem_wdata_o,
    output logic [1:0]            mem_be_o,
    input  logic [15:0]           mem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE, CA, LAT, RD, WR, REGWR, HOLD
    } state_t;

    localparam logic [3:0] LAST_LAT = 4'(2 * LATENCY - 1);

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] hdr_q, hdr_d;
    logic [28:0] ahi_q, ahi_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic armed_q, armed_d;

    logic dq_oe_d, rwds_d, rwds_oe_d;
    logic req_d, we_d;
    logic [ADDR_WIDTH-1:0] maddr_d;
    logic [15:0] wdata_d;
    logic [1:0] be_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hdr_d     = hdr_q;
        ahi_d     = ahi_q;
        addr_d    = addr_q;
        armed_d   = armed_q | cs_ni;
        dq_oe_d   = 1'b0;
        rwds_d    = 1'b0;
        rwds_oe_d = 1'b0;
        req_d     = 1'b0;
        we_d      = 1'b0;
        maddr_d   = mem_addr_o;
        wdata_d   = mem_wdata_o;
        be_d      = 2'b00;
        if (cs_ni && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!cs_ni && armed_q) begin
                        state_d       = CA;
                        cnt_d         = 4'd1;
                        hdr_d         = dq_i[15:14];
                        ahi_d[28:16]  = dq_i[12:0];
                        rwds_oe_d     = 1'b1;
                        rwds_d        = 1'b1;
                    end
                end
                CA: begin
                    rwds_oe_d = 1'b1;
                    rwds_d    = 1'b1;
                    if (cnt_q == 4'd1) begin
                        ahi_d[15:0] = dq_i;
                        cnt_d       = 4'd2;
                    end else begin
                        addr_d = ADDR_WIDTH'({ahi_q, dq_i[2:0]});
                        cnt_d  = 4'd3;
                        // register writes carry their word with no latency
                        if (!hdr_q[1] && hdr_q[0])
                            state_d = REGWR;
                        else
                            state_d = LAT;
                    end
                end
                LAT: begin
                    rwds_oe_d = hdr_q[1];
                    cnt_d     = cnt_q + 4'd1;
                    if (cnt_q == LAST_LAT) begin
                        if (hdr_q[1]) begin
                            state_d = RD;
                            req_d   = !hdr_q[0];
                            maddr_d = addr_q;
                            addr_d  = addr_q + 1'b1;
                        end else begin
                            state_d = WR;
                        end
                    end
                end
                RD: begin
                    rwds_oe_d = 1'b1;
                    rwds_d    = 1'b1;
                    dq_oe_d   = 1'b1;
                    req_d     = !hdr_q[0];
                    maddr_d   = addr_q;
                    addr_d    = addr_q + 1'b1;
                end
                WR: begin
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    maddr_d = addr_q;
                    wdata_d = dq_i;
                    be_d    = ~rwds_i;
                    addr_d  = addr_q + 1'b1;
                end
                REGWR: state_d = HOLD;
                HOLD: state_d = HOLD;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hdr_q       <= '0;
            ahi_q       <= '0;
            addr_q      <= '0;
            armed_q     <= 1'b0;
            dq_oe_o     <= 1'b0;
            rwds_o      <= 1'b0;
            rwds_oe_o   <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hdr_q       <= hdr_d;
            ahi_q       <= ahi_d;
            addr_q      <= addr_d;
            armed_q     <= armed_d;
            dq_oe_o     <= dq_oe_d;
            rwds_o      <= rwds_d;
            rwds_oe_o   <= rwds_oe_d;
            mem_req_o   <= req_d;
            mem_we_o    <= we_d;
            mem_addr_o  <= maddr_d;
            mem_wdata_o <= wdata_d;
            mem_be_o    <= be_d;
        end
    end

    // read data arrives one cycle after the request, so it is muxed, not re-registered
    assign dq_o = dq_oe_o ? (hdr_q[0] ? ID_REG : mem_rdata_i) : 16'h0000;

endmodule

// File: tb/tb_hyperbus_responder.sv
// Directed, table-driven bench for hyperbus_responder with a
// behavioural word memory behind the memory port.
module tb_hyperbus_responder;

    logic        clk;
    logic        rst_ni;
    logic        cs_ni;
    logic [15:0] dq_i;
    logic [1:0]  rwds_i;
    logic [15:0] dq_o;
    logic        dq_oe_o;
    logic        rwds_o;
    logic        rwds_oe_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [15:0] mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic [1:0]  mem_be_o;
    logic [15:0] mem_rdata_i;

    logic [15:0] mem [0:65535];

    int n_pass;
    int n_tot;

    hyperbus_responder #(
        .ADDR_WIDTH(16),
        .LATENCY(6),
        .ID_REG(16'h0C81)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .cs_ni(cs_ni),
        .dq_i(dq_i),
        .rwds_i(rwds_i),
        .dq_o(dq_o),
        .dq_oe_o(dq_oe_o),
        .rwds_o(rwds_o),
        .rwds_oe_o(rwds_oe_o),
        .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_be_o(mem_be_o),
        .mem_rdata_i(mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                if (mem_be_o[1]) mem[mem_addr_o][15:8] <= mem_wdata_o[15:8];
                if (mem_be_o[0]) mem[mem_addr_o][7:0] <= mem_wdata_o[7:0];
            end else begin
                mem_rdata_i <= mem[mem_addr_o];
            end
        end
    end

    typedef struct {
        logic        cs_n;
        logic [15:0] dq;
        logic [1:0]  rwds;
        logic        rc;
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [1:0]  be;
        logic        oe;
        logic [15:0] dqv;
        logic        roe;
        logic        rw;
    } vec_t;

    vec_t tv[$];

    function automatic void add(
        input logic cs_n, input logic [15:0] dq, input logic [1:0] rwds,
        input logic rc, input logic req, input logic we,
        input logic [15:0] addr, input logic [15:0] wd, input logic [1:0] be,
        input logic oe, input logic [15:0] dqv,
        input logic roe, input logic rw);
        vec_t v;
        v.cs_n = cs_n; v.dq = dq; v.rwds = rwds;
        v.rc = rc; v.req = req; v.we = we;
        v.addr = addr; v.wd = wd; v.be = be;
        v.oe = oe; v.dqv = dqv; v.roe = roe; v.rw = rw;
        tv.push_back(v);
    endfunction

    function automatic void idle();
        add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic void ca3(input logic [15:0] w0, w1, w2);
        add(0, w0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        add(0, w1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        add(0, w2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    endfunction

    function automatic void lat(input int n, input logic roe);
        for (int k = 0; k < n; k++)
            add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, roe, 0);
    endfunction

    function automatic void rd_txn();
        idle(); idle();
        ca3(16'h8000, 16'h0000, 16'h0002);
        lat(8, 1);
        add(0, 0, 0, 1, 1, 0, 16'h0002, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 1, 0, 16'h0003, 0, 0, 1, 16'hA5A5, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h5A5A, 1, 1);
        idle();
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            cs_ni  = tv[i].cs_n;
            dq_i   = tv[i].dq;
            rwds_i = tv[i].rwds;
            @(posedge clk);
            #1;
            if (tv[i].rc) chk("mem_req", i, 16'(mem_req_o), 16'(tv[i].req));
            if (tv[i].rc && tv[i].req) begin
                chk("mem_we", i, 16'(mem_we_o), 16'(tv[i].we));
                chk("mem_addr", i, mem_addr_o, tv[i].addr);
                if (tv[i].we) begin
                    chk("mem_wdata", i, mem_wdata_o, tv[i].wd);
                    chk("mem_be", i, 16'(mem_be_o), 16'(tv[i].be));
                end
            end
            chk("dq_oe", i, 16'(dq_oe_o), 16'(tv[i].oe));
            if (tv[i].oe) chk("dq", i, dq_o, tv[i].dqv);
            chk("rwds_oe", i, 16'(rwds_oe_o), 16'(tv[i].roe));
            if (tv[i].roe) chk("rwds", i, 16'(rwds_o), 16'(tv[i].rw));
        end
    endtask

    initial begin
        n_pass = 0;
        n_tot  = 0;
        mem[2] = 16'hA5A5;
        mem[3] = 16'h5A5A;
        mem_rdata_i = 16'h0000;

        rd_txn();
        idle();
        ca3(16'h0000, 16'h0000, 16'h0000);
        lat(9, 0);
        add(0, 16'h1234, 2'b00, 1, 1, 1, 16'h0000, 16'h1234, 2'b11, 0, 0, 0, 0);
        add(0, 16'hBEEF, 2'b01, 1, 1, 1, 16'h0001, 16'hBEEF, 2'b10, 0, 0, 0, 0);
        idle();
        idle();
        ca3(16'h0000, 16'h1FFF, 16'h0007);
        lat(9, 0);
        add(0, 16'hCAFE, 2'b10, 1, 1, 1, 16'hFFFF, 16'hCAFE, 2'b01, 0, 0, 0, 0);
        add(0, 16'hF00D, 2'b11, 1, 1, 1, 16'h0000, 16'hF00D, 2'b00, 0, 0, 0, 0);
        idle();
        idle();
        ca3(16'hC000, 16'h0000, 16'h0000);
        lat(8, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 16'h0C81, 1, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 16'h0C81, 1, 1);
        idle();
        idle();
        ca3(16'h4000, 16'h0000, 16'h0000);
        add(0, 16'hDEAD, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lat(3, 0);
        idle();
        idle();
        add(0, 16'h8000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(); idle(); idle();
        rd_txn();

        rst_ni = 1'b0;
        cs_ni  = 1'b0;
        dq_i   = 16'h8000;
        rwds_i = 2'b00;
        #12;
        chk("rst_dq_oe", -1, 16'(dq_oe_o), 16'h0);
        chk("rst_rwds_oe", -1, 16'(rwds_oe_o), 16'h0);
        chk("rst_req", -1, 16'(mem_req_o), 16'h0);
        chk("rst_addr", -1, mem_addr_o, 16'h0);
        chk("rst_dq", -1, dq_o, 16'h0);

        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("arm_rwds_oe", k, 16'(rwds_oe_o), 16'h0);
            chk("arm_req", k, 16'(mem_req_o), 16'h0);
        end

        apply(0, tv.size() - 1);

        apply(0, 15);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("midrst_dq_oe", -2, 16'(dq_oe_o), 16'h0);
        chk("midrst_rwds_oe", -2, 16'(rwds_oe_o), 16'h0);
        chk("midrst_req", -2, 16'(mem_req_o), 16'h0);
        chk("midrst_dq", -2, dq_o, 16'h0);
        cs_ni = 1'b1;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        apply(0, 16);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/hyperbus_responder.md
HYPERBUS_RESPONDER -- requirements
Module: hyperbus_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, word-address width of the backing memory port.
REQ-002 Parameter LATENCY, default 6, initial latency in clock cycles (legal 3..7).
REQ-003 Parameter ID_REG, default 16'h0C81, value returned for register-space reads.
REQ-004 clk_i  input  1  sole clock; one bus word (DDR byte pair, pre-assembled) per cycle.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 cs_ni  input  1  chip select from initiator, active-low.
REQ-007 dq_i  input  16  CA/write word; [15:8] = first (rising-edge) byte.
REQ-008 rwds_i  input  2  write byte mask, bit1 masks dq_i[15:8], 1 = masked.
REQ-009 dq_o  output  16  read data word.
REQ-010 dq_oe_o  output  1  dq_o drive enable.
REQ-011 rwds_o  output  1  read-word strobe / latency indicator.
REQ-012 rwds_oe_o  output  1  rwds_o drive enable.
REQ-013 mem_req_o  output  1  backing-memory access strobe, one access per cycle.
REQ-014 mem_we_o  output  1  1 = write.
REQ-015 mem_addr_o  output  ADDR_WIDTH  word address.
REQ-016 mem_wdata_o  output  16  write data.
REQ-017 mem_be_o  output  2  byte enables, bit1 = [15:8].
REQ-018 mem_rdata_i  input  16  read data, valid exactly one cycle after mem_req_o with mem_we_o=0.

Function
REQ-019 States: IDLE, CA, LAT, RD, WR, REGWR, HOLD; transitions on clk_i rising edge only.
REQ-020 IDLE->CA when cs_ni=0; CA samples dq_i in cycles 0,1,2 (cycle 0 = first cycle cs_ni sampled low) into CA[47:0], MSW first.
REQ-021 CA decode: CA[47]=1 read, CA[46]=1 register space, CA[45] ignored (linear burst only), start address = {CA[44:16],CA[2:0]} truncated to ADDR_WIDTH.
REQ-022 During CA cycles: rwds_oe_o=1, rwds_o=1 (fixed 2x latency signalled); dq_oe_o=0.
REQ-023 Memory read/write: LAT state until data phase; first data word is in cycle 2*LATENCY (counted from cycle 0).
REQ-024 Register write (CA[47]=0, CA[46]=1): zero latency, word in cycle 3 consumed and discarded, then HOLD; no mem_req_o.
REQ-025 Register read: follows read timing, drives ID_REG every data cycle, no mem_req_o.
REQ-026 LAT on read: rwds_oe_o=1, rwds_o=0; dq_oe_o=0. LAT on write: rwds_oe_o=0.
REQ-027 RD: mem_req_o (we=0) issued cycle k for address A, dq_o=mem_rdata_i with dq_oe_o=1, rwds_o=1 in cycle k+1; first request in cycle 2*LATENCY-1; one request per cycle, address +1 each.
REQ-028 WR: each data cycle with cs_ni=0: mem_req_o=1, mem_we_o=1, mem_wdata_o=dq_i, mem_be_o=~rwds_i, address +1 per word; fully masked words still issue req with be=2'b00.
REQ-029 Address increment wraps 2^ADDR_WIDTH-1 -> 0.
REQ-030 cs_ni sampled high in any non-IDLE state: state -> IDLE next edge; all enables and mem_req_o 0 from that edge; no write for that cycle.
REQ-031 cs_ni high during CA (fewer than 3 words): transaction discarded, no memory access.
REQ-032 One speculative read request after cs_ni rise is permitted; its data is never driven.
REQ-033 HOLD: outputs idle until cs_ni high, then IDLE.
REQ-034 All outputs registered; no combinational path dq_i/cs_ni -> outputs.

Reset
REQ-035 rst_ni low: state IDLE, address 0, all outputs 0 immediately, including mid-burst.
REQ-036 After rst_ni release: first CA accepted only on a fresh cs_ni low (cs_ni must be sampled high once).

Verification
REQ-037 Read CA 16'h8000,16'h0000,16'h0002, LATENCY=6, mem preloaded addr2=16'hA5A5, addr3=16'h5A5A, cs low 14 cycles -> mem_req cycles 11,12; dq_o=A5A5 cycle 12, 5A5A cycle 13, rwds_o=1 both.
REQ-038 Write CA 0x0000/0x0000/0x0000, words 16'h1234,16'hBEEF with rwds_i 2'b00, 2'b01 -> writes addr0 be=11 data 1234, addr1 be=10 data BEEF, cycles 12,13.
REQ-039 Write CA at address 2^ADDR_WIDTH-1, two words -> second write to address 0.
REQ-040 Register read CA 16'hC000,0,0 -> ID_REG driven from cycle 12, no mem_req_o; register write -> word cycle 3 dropped, no mem_req_o.
REQ-041 cs_ni high after CA word 1 -> no mem_req_o, all enables 0; next full read transaction correct.
REQ-042 rst_ni low during RD cycle 13 -> dq_oe_o, rwds_oe_o, mem_req_o 0 immediately; state IDLE.
